// File: rtl/axis_i2c_target_rx_if.sv
// AXI-Stream handshake bundle (tdata/tvalid/tready) shared by the I2C stream blocks.
interface axis_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_i2c_target_rx.sv
// Oversampling I2C write-only target: receives address + data bytes LSB first,
// ACKs via open-drain enable and emits {byte, rw, addr} words on an AXIS master.
module axis_i2c_target_rx #(
    parameter int                        I2C_ADDR_WIDTH  = 7,
    parameter int                        I2C_DATA_WIDTH  = 8,
    parameter int                        AXIS_DATA_WIDTH = I2C_DATA_WIDTH * 2,
    parameter logic [I2C_ADDR_WIDTH-1:0] OWN_ADDR        = 7'h50
) (
    input  logic   clk,
    input  logic   arstn,
    input  logic   scl,
    input  logic   sda,
    output logic   sda_oe,
    output logic   busy,
    output logic   overflow,
    axis_if.master m_axis
);
    localparam int FIELD_MAX = (I2C_ADDR_WIDTH > I2C_DATA_WIDTH) ? I2C_ADDR_WIDTH : I2C_DATA_WIDTH;
    localparam int CW        = $clog2(FIELD_MAX + 1);

    typedef enum logic [2:0] {IDLE, ADDR, ACK_ADDR, DATA, ACK_DATA, WAIT_STOP} state_t;

    // Bit 0 = scl, bit 1 = sda; two metastability flops then one edge-detect flop.
    logic [1:0] sync0_reg, sync1_reg, prev_reg;

    always_ff @(posedge clk) begin
        if (!arstn) begin
            sync0_reg <= 2'b11;
            sync1_reg <= 2'b11;
            prev_reg  <= 2'b11;
        end else begin
            sync0_reg <= {sda, scl};
            sync1_reg <= sync0_reg;
            prev_reg  <= sync1_reg;
        end
    end

    logic scl_s, sda_s, scl_p, sda_p;
    logic scl_rise, scl_fall, start_evt, stop_evt;

    assign scl_s     = sync1_reg[0];
    assign sda_s     = sync1_reg[1];
    assign scl_p     = prev_reg[0];
    assign sda_p     = prev_reg[1];
    assign scl_rise  = scl_s & ~scl_p;
    assign scl_fall  = ~scl_s & scl_p;
    assign start_evt = scl_s & scl_p & sda_p & ~sda_s;
    assign stop_evt  = scl_s & scl_p & ~sda_p & sda_s;

    state_t                     state_reg;
    logic [CW-1:0]              cnt_reg;
    logic [I2C_ADDR_WIDTH-1:0]  addr_reg, addr_next;
    logic [I2C_DATA_WIDTH-1:0]  data_reg, data_next;
    logic                       rw_reg;
    logic [AXIS_DATA_WIDTH-1:0] tdata_reg;
    logic                       tvalid_reg;

    // Field registers with the current sample dropped into bit position cnt_reg.
    generate
        for (genvar gi = 0; gi < I2C_ADDR_WIDTH; gi++) begin : g_addr_bit
            assign addr_next[gi] = (cnt_reg == CW'(gi)) ? sda_s : addr_reg[gi];
        end
        for (genvar gi = 0; gi < I2C_DATA_WIDTH; gi++) begin : g_data_bit
            assign data_next[gi] = (cnt_reg == CW'(gi)) ? sda_s : data_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            data_reg   <= '0;
            rw_reg     <= 1'b0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (tvalid_reg && m_axis.tready)
                tvalid_reg <= 1'b0;

            if (start_evt) begin
                state_reg <= ADDR;
                cnt_reg   <= '0;
                busy      <= 1'b1;
                sda_oe    <= 1'b0;
            end else if (stop_evt) begin
                state_reg <= IDLE;
                cnt_reg   <= '0;
                busy      <= 1'b0;
                sda_oe    <= 1'b0;
            end else begin
                case (state_reg)
                    ADDR: if (scl_rise) begin
                        if (cnt_reg == CW'(I2C_ADDR_WIDTH)) begin
                            rw_reg  <= sda_s;
                            cnt_reg <= '0;
                            state_reg <= (addr_reg == OWN_ADDR && !sda_s) ? ACK_ADDR : WAIT_STOP;
                        end else begin
                            addr_reg <= addr_next;
                            cnt_reg  <= cnt_reg + CW'(1);
                        end
                    end
                    // First falling edge drives the ACK, the next one releases it.
                    ACK_ADDR, ACK_DATA: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe    <= 1'b0;
                            cnt_reg   <= '0;
                            state_reg <= DATA;
                        end
                    end
                    DATA: if (scl_rise) begin
                        data_reg <= data_next;
                        if (cnt_reg == CW'(I2C_DATA_WIDTH - 1)) begin
                            cnt_reg <= '0;
                            if (!tvalid_reg || m_axis.tready) begin
                                tdata_reg  <= {data_next, rw_reg, addr_reg};
                                tvalid_reg <= 1'b1;
                                state_reg  <= ACK_DATA;
                            end else begin
                                overflow  <= 1'b1;
                                state_reg <= WAIT_STOP;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign m_axis.tdata  = tdata_reg;
    assign m_axis.tvalid = tvalid_reg;
endmodule

// File: tb/tb_axis_i2c_target_rx.sv
// Directed bench: bit-bangs I2C frames at the target and checks ACKs and AXIS words.
module tb_axis_i2c_target_rx;
    logic clk = 1'b0;
    logic arstn = 1'b0;
    logic scl = 1'b1;
    logic sda_m = 1'b1;
    logic sda_bus;
    logic sda_oe, busy, overflow;

    axis_if #(.DATA_WIDTH(16)) m_axis_if ();

    axis_i2c_target_rx dut (
        .clk      (clk),
        .arstn    (arstn),
        .scl      (scl),
        .sda      (sda_bus),
        .sda_oe   (sda_oe),
        .busy     (busy),
        .overflow (overflow),
        .m_axis   (m_axis_if)
    );

    always #5 clk = ~clk;
    assign sda_bus = sda_m & ~sda_oe;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int          ovf_cnt  = 0;
    logic        oe_seen  = 1'b0;
    logic [15:0] words_q[$];

    always @(negedge clk) begin
        if (m_axis_if.tvalid && m_axis_if.tready) begin
            words_q.push_back(m_axis_if.tdata);
            $display("word accepted tdata=%h", m_axis_if.tdata);
        end
        if (overflow) ovf_cnt++;
        if (sda_oe) oe_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic wait_q();
        repeat (10) @(posedge clk);
        #2;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl = 1'b1;   wait_q();
        sda_m = 1'b0; wait_q();
        scl = 1'b0;   wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl = 1'b1;   wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b, output logic line);
        sda_m = b;  wait_q();
        scl = 1'b1; wait_q();
        line = sda_bus;
        wait_q();
        scl = 1'b0; wait_q();
    endtask

    // Bits go out LSB first, then one released clock to read the ACK.
    task automatic send_byte(input logic [7:0] v, output logic ack);
        logic line;
        for (int i = 0; i < 8; i++) send_bit(v[i], line);
        send_bit(1'b1, line);
        ack = ~line;
        $display("byte %h sent, ack=%0b", v, ack);
    endtask

    task automatic clear_mon();
        words_q.delete();
        ovf_cnt = 0;
        oe_seen = 1'b0;
    endtask

    logic ack_a, ack_d, line;
    logic [15:0] w;

    initial begin
        m_axis_if.tready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_sda_oe", sda_oe, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overflow", overflow, 0);
        check_eq("rst_tvalid", m_axis_if.tvalid, 0);
        check_eq("rst_tdata", m_axis_if.tdata, 0);
        arstn = 1'b1;
        wait_q();

        // Basic write 0x50 <- 0xA5
        clear_mon();
        i2c_start();
        send_byte(8'h50, ack_a);
        send_byte(8'hA5, ack_d);
        check_eq("t1_addr_ack", ack_a, 1);
        check_eq("t1_data_ack", ack_d, 1);
        check_eq("t1_busy", busy, 1);
        i2c_stop();
        check_eq("t1_busy_stop", busy, 0);
        check_eq("t1_words", words_q.size(), 1);
        w = (words_q.size() > 0) ? words_q[0] : 16'h0;
        check_eq("t1_tdata", w, 16'hA550);

        // Wrong address 0x51
        clear_mon();
        i2c_start();
        send_byte(8'h51, ack_a);
        send_byte(8'h33, ack_d);
        check_eq("t2_oe_seen", oe_seen, 0);
        check_eq("t2_busy", busy, 1);
        i2c_stop();
        check_eq("t2_busy_stop", busy, 0);
        check_eq("t2_words", words_q.size(), 0);

        // Read request to own address is refused
        clear_mon();
        i2c_start();
        send_byte(8'hD0, ack_a);
        send_byte(8'h12, ack_d);
        check_eq("t3_addr_ack", ack_a, 0);
        check_eq("t3_data_ack", ack_d, 0);
        check_eq("t3_oe_seen", oe_seen, 0);
        i2c_stop();
        check_eq("t3_words", words_q.size(), 0);

        // Backpressure: second byte overflows
        clear_mon();
        m_axis_if.tready = 1'b0;
        i2c_start();
        send_byte(8'h50, ack_a);
        send_byte(8'h11, ack_d);
        check_eq("t4_ack1", ack_d, 1);
        send_byte(8'h22, ack_d);
        check_eq("t4_ack2", ack_d, 0);
        check_eq("t4_ovf_pulses", ovf_cnt, 1);
        check_eq("t4_tvalid_held", m_axis_if.tvalid, 1);
        check_eq("t4_tdata_held", m_axis_if.tdata, 16'h1150);
        i2c_stop();
        m_axis_if.tready = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check_eq("t4_words", words_q.size(), 1);
        w = (words_q.size() > 0) ? words_q[0] : 16'h0;
        check_eq("t4_drained", w, 16'h1150);
        check_eq("t4_tvalid_clr", m_axis_if.tvalid, 0);

        // Repeated START after 3 address bits
        clear_mon();
        i2c_start();
        send_bit(1'b0, line);
        send_bit(1'b0, line);
        send_bit(1'b1, line);
        i2c_start();
        send_byte(8'h50, ack_a);
        send_byte(8'h7E, ack_d);
        i2c_stop();
        check_eq("t5_ack", ack_d, 1);
        check_eq("t5_words", words_q.size(), 1);
        w = (words_q.size() > 0) ? words_q[0] : 16'h0;
        check_eq("t5_tdata", w, 16'h7E50);

        // Reset mid-DATA
        clear_mon();
        i2c_start();
        send_byte(8'h50, ack_a);
        for (int i = 0; i < 4; i++) send_bit(1'b1, line);
        @(posedge clk); #2;
        arstn = 1'b0;
        @(posedge clk); #2;
        check_eq("t6_rst_oe", sda_oe, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_tvalid", m_axis_if.tvalid, 0);
        arstn = 1'b1;
        for (int i = 0; i < 4; i++) send_bit(1'b0, line);
        send_bit(1'b1, line);
        check_eq("t6_no_ack", line, 1);
        check_eq("t6_busy_idle", busy, 0);
        i2c_stop();
        check_eq("t6_words_none", words_q.size(), 0);
        i2c_start();
        send_byte(8'h50, ack_a);
        send_byte(8'h3C, ack_d);
        i2c_stop();
        check_eq("t6_next_ack", ack_d, 1);
        check_eq("t6_words", words_q.size(), 1);
        w = (words_q.size() > 0) ? words_q[0] : 16'h0;
        check_eq("t6_tdata", w, 16'h3C50);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
